// File: rtl/vector_regfile_credit.sv
// Per-lane banked vector register file: byte-enabled single-port banks whose read
// data is steered into credit-protected operand FIFOs, one push per queue per cycle.
module vector_regfile_credit #(
    parameter int NrBanks         = 8,
    parameter int VRFSize         = 16384,
    parameter int DataWidth       = 64,
    parameter int NrOperandQueues = 10,
    parameter int ReadLatency     = 1,
    parameter int BufDepth        = 2,
    localparam int NumWords       = VRFSize / NrBanks / DataWidth,
    localparam int AddrWidth      = $clog2(NumWords),
    localparam int StrbWidth      = DataWidth / 8,
    localparam int QIdxW          = $clog2(NrOperandQueues)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NrBanks-1:0]                   req_i,
    output logic [NrBanks-1:0]                   gnt_o,
    input  logic [NrBanks*AddrWidth-1:0]         addr_i,
    input  logic [NrBanks-1:0]                   wen_i,
    input  logic [NrBanks*DataWidth-1:0]         wdata_i,
    input  logic [NrBanks*StrbWidth-1:0]         be_i,
    input  logic [NrBanks*QIdxW-1:0]             tgt_opqueue_i,
    output logic [NrOperandQueues*DataWidth-1:0] operand_o,
    output logic [NrOperandQueues-1:0]           operand_valid_o,
    input  logic [NrOperandQueues-1:0]           operand_ready_i
);

    localparam int CntW = $clog2(BufDepth + 1);
    localparam int PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;

    logic [AddrWidth-1:0]       w_addr      [NrBanks];
    logic [QIdxW-1:0]           w_tgt       [NrBanks];
    logic [NrBanks-1:0]         w_gnt;
    logic [NrBanks-1:0]         w_rd_gnt;
    logic [NrBanks-1:0]         w_arr_valid;
    logic [QIdxW-1:0]           w_arr_q     [NrBanks];
    logic [DataWidth-1:0]       w_arr_data  [NrBanks];
    logic [PtrW-1:0]            w_arr_idx   [NrBanks];
    int                         w_cred      [NrOperandQueues];
    int                         w_grant_cnt [NrOperandQueues];
    int                         w_arr_cnt   [NrOperandQueues];
    logic [NrOperandQueues-1:0] w_push;
    logic [NrOperandQueues-1:0] w_pop;

    // Each queue buffer holds r_occ visible entries from r_rptr, followed by
    // r_pend entries that have arrived but not yet been pushed (one per cycle).
    logic [DataWidth-1:0]       r_buf       [NrOperandQueues][BufDepth];
    logic [PtrW-1:0]            r_rptr      [NrOperandQueues];
    logic [CntW-1:0]            r_occ       [NrOperandQueues];
    logic [CntW-1:0]            r_pend      [NrOperandQueues];
    logic [CntW-1:0]            r_inflight  [NrOperandQueues];

    for (genvar b = 0; b < NrBanks; b++) begin : g_unpack
        assign w_addr[b] = addr_i[b*AddrWidth +: AddrWidth];
        assign w_tgt[b]  = tgt_opqueue_i[b*QIdxW +: QIdxW];
    end

    // NOTE: always_comb uses blocking '=' and assigns every output a default first,
    // so the running credit is read back correctly and no latch is inferred.
    always_comb begin
        w_gnt    = '0;
        w_rd_gnt = '0;
        for (int q = 0; q < NrOperandQueues; q++) begin
            w_cred[q]      = BufDepth - int'(r_occ[q]) - int'(r_inflight[q]);
            w_grant_cnt[q] = 0;
        end
        if (!rst_i) begin
            for (int b = 0; b < NrBanks; b++) begin
                if (req_i[b] && wen_i[b]) begin
                    w_gnt[b] = 1'b1;
                end else if (req_i[b] && (int'(w_tgt[b]) < NrOperandQueues)) begin
                    if (w_cred[w_tgt[b]] > 0) begin
                        w_gnt[b]                 = 1'b1;
                        w_rd_gnt[b]              = 1'b1;
                        w_cred[w_tgt[b]]         = w_cred[w_tgt[b]] - 1;
                        w_grant_cnt[w_tgt[b]]    = w_grant_cnt[w_tgt[b]] + 1;
                    end
                end
            end
        end
    end

    assign gnt_o = w_gnt;

    for (genvar b = 0; b < NrBanks; b++) begin : g_bank
        logic [DataWidth-1:0] r_mem [NumWords];
        logic [DataWidth-1:0] r_s1_data;
        logic                 r_s1_valid;
        logic [QIdxW-1:0]     r_s1_q;

        // NOTE: the array and data registers carry no reset; only valids and
        // counters are cleared, which is enough to discard in-flight reads.
        always_ff @(posedge clk_i) begin
            if (w_gnt[b] && wen_i[b]) begin
                for (int i = 0; i < StrbWidth; i++) begin
                    if (be_i[b*StrbWidth + i]) begin
                        r_mem[w_addr[b]][8*i +: 8] <= wdata_i[b*DataWidth + 8*i +: 8];
                    end
                end
            end
            if (w_rd_gnt[b]) begin
                r_s1_data <= r_mem[w_addr[b]];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_s1_valid <= 1'b0;
                r_s1_q     <= '0;
            end else begin
                r_s1_valid <= w_rd_gnt[b];
                if (w_rd_gnt[b]) begin
                    r_s1_q <= w_tgt[b];
                end
            end
        end

        if (ReadLatency == 2) begin : g_lat2
            logic [DataWidth-1:0] r_s2_data;
            logic                 r_s2_valid;
            logic [QIdxW-1:0]     r_s2_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_s2_valid <= 1'b0;
                    r_s2_q     <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    r_s2_q     <= r_s1_q;
                end
            end

            always_ff @(posedge clk_i) begin
                r_s2_data <= r_s1_data;
            end

            assign w_arr_valid[b] = r_s2_valid;
            assign w_arr_q[b]     = r_s2_q;
            assign w_arr_data[b]  = r_s2_data;
        end else begin : g_lat1
            assign w_arr_valid[b] = r_s1_valid;
            assign w_arr_q[b]     = r_s1_q;
            assign w_arr_data[b]  = r_s1_data;
        end
    end

    // Arrivals to the same queue take consecutive slots in ascending bank order.
    always_comb begin
        for (int q = 0; q < NrOperandQueues; q++) begin
            w_arr_cnt[q] = 0;
        end
        for (int b = 0; b < NrBanks; b++) begin
            w_arr_idx[b] = '0;
            if (w_arr_valid[b]) begin
                w_arr_idx[b] = PtrW'((int'(r_rptr[w_arr_q[b]]) + int'(r_occ[w_arr_q[b]]) +
                                      int'(r_pend[w_arr_q[b]]) + w_arr_cnt[w_arr_q[b]]) % BufDepth);
                w_arr_cnt[w_arr_q[b]] = w_arr_cnt[w_arr_q[b]] + 1;
            end
        end
        for (int q = 0; q < NrOperandQueues; q++) begin
            w_push[q] = (int'(r_pend[q]) + w_arr_cnt[q]) > 0;
            w_pop[q]  = (r_occ[q] != '0) && operand_ready_i[q];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NrBanks; b++) begin
            if (w_arr_valid[b]) begin
                r_buf[w_arr_q[b]][w_arr_idx[b]] <= w_arr_data[b];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int q = 0; q < NrOperandQueues; q++) begin
                r_rptr[q]     <= '0;
                r_occ[q]      <= '0;
                r_pend[q]     <= '0;
                r_inflight[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NrOperandQueues; q++) begin
                r_occ[q]      <= CntW'(int'(r_occ[q]) + int'(w_push[q]) - int'(w_pop[q]));
                r_pend[q]     <= CntW'(int'(r_pend[q]) + w_arr_cnt[q] - int'(w_push[q]));
                r_inflight[q] <= CntW'(int'(r_inflight[q]) + w_grant_cnt[q] - int'(w_push[q]));
                if (w_pop[q]) begin
                    r_rptr[q] <= PtrW'((int'(r_rptr[q]) + 1) % BufDepth);
                end
            end
        end
    end

    // Credit accounting must keep every queued or arriving entry inside the buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int q = 0; q < NrOperandQueues; q++) begin
                assert (int'(r_occ[q]) + int'(r_pend[q]) + w_arr_cnt[q] <= BufDepth);
                assert (w_cred[q] >= 0);
            end
        end
    end

    for (genvar q = 0; q < NrOperandQueues; q++) begin : g_out
        assign operand_valid_o[q]                     = (r_occ[q] != '0);
        assign operand_o[q*DataWidth +: DataWidth]    = operand_valid_o[q] ? r_buf[q][r_rptr[q]] : '0;
    end

endmodule
